multicycle_control: RTL

- Main control FSM for the multicycle Mini-MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback per instruction and drives the datapath strobes.
- Produces the 3-bit ALUop consumed by alu_control. It is the producer end of the ALUop/func interface: ALUop 110 defers to func, all other values are fixed operations.

---
 rtl/multicycle_control.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle Mini-MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Latency: R/I 4, lw 5, sw 4, beq/bne/j 3, illegal 2 cycles; each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one.
// Backpressure: memory states hold until mem_ready (ignored when USE_MEM_READY=0); no strobes survive reset.
module multicycle_control #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] ALUop,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        RESET_ST, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU,
        MEM_ADDR, MEM_READ, WB_MEM, MEM_WRITE, BRANCH, JUMP
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_NORI = 4'b0100;
    localparam logic [3:0] OP_SLTI = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_J    = 4'b1010;

    state_t     state;
    logic [3:0] op_q;
    logic       ready;

    assign ready = USE_MEM_READY ? mem_ready : 1'b1;

    // State register and opcode latch; op_q is captured in DECODE and used by every later state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_ST;
            op_q  <= 4'b0000;
        end else begin
            case (state)
                RESET_ST: state <= FETCH;
                FETCH:    if (ready) state <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_R:                                        state <= EXEC_R;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_NORI, OP_SLTI:  state <= EXEC_I;
                        OP_LW, OP_SW:                                state <= MEM_ADDR;
                        OP_BEQ, OP_BNE:                              state <= BRANCH;
                        OP_J:                                        state <= JUMP;
                        default:                                     state <= FETCH;
                    endcase
                end
                EXEC_R, EXEC_I: state <= WB_ALU;
                MEM_ADDR:  state <= (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
                MEM_READ:  if (ready) state <= WB_MEM;
                MEM_WRITE: if (ready) state <= FETCH;
                WB_ALU, WB_MEM, BRANCH, JUMP: state <= FETCH;
                default:   state <= RESET_ST;
            endcase
        end
    end

    // Output decode from state and op_q; only the fetch/store completion strobes look at mem_ready,
    // and DECODE must judge legality from the live opcode since op_q loads at the end of that cycle
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ALUop         = 3'b000;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                if (opcode > OP_J) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                ALUop     = 3'b110;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ANDI: ALUop = 3'b010;
                    OP_ORI:  ALUop = 3'b011;
                    OP_NORI: ALUop = 3'b100;
                    OP_SLTI: ALUop = 3'b101;
                    default: ALUop = 3'b000;
                endcase
            end
            WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R);
                instr_done = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = ready;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                ALUop         = 3'b001;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_ne     = (op_q == OP_BNE);
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
